// File: rtl/soc_run_monitor.sv
// End-of-test monitor: snoops per-core data-memory writes for flag/result words, gates
// fetch enables and reports done/pass/timeout along with the run-cycle count.
module soc_run_monitor #(
  parameter int unsigned       NUM_CH      = 1,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] FLAG_BASE   = '0,
  parameter int unsigned       RESULT_OFS  = 4,
  parameter int unsigned       CH_STRIDE   = 8,
  parameter int unsigned       TIMEOUT_CYC = 100,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NUM_CH-1:0]        wr_valid_i,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
  output logic [NUM_CH-1:0]        fetch_en_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH*DATA_W-1:0] result_o,
  output logic [NUM_CH*DATA_W-1:0] flag_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         cycles_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StTimeout
  } state_e;

  state_e                     r_state;
  logic [NUM_CH-1:0]          r_fetch_en;
  logic [NUM_CH-1:0]          r_ch_done;
  logic [NUM_CH*DATA_W-1:0]   r_result;
  logic [NUM_CH*DATA_W-1:0]   r_flag;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_pass;
  logic                       r_timeout;
  logic [CNT_W-1:0]           r_cycles;

  logic [ADDR_W-1:0]          w_addr [NUM_CH];
  logic [DATA_W-1:0]          w_data [NUM_CH];
  logic [NUM_CH-1:0]          w_flag_hit;
  logic [NUM_CH-1:0]          w_res_hit;
  logic [NUM_CH*DATA_W-1:0]   w_flag_nxt;
  logic                       w_all_done;
  logic                       w_expire;
  logic                       w_pass_nxt;

  function automatic logic [ADDR_W-1:0] flag_addr(input int unsigned k);
    return FLAG_BASE + ADDR_W'(k * CH_STRIDE);
  endfunction

  function automatic logic [ADDR_W-1:0] result_addr(input int unsigned k);
    return flag_addr(k) + ADDR_W'(RESULT_OFS);
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_addr[k] = wr_addr_i[k*ADDR_W +: ADDR_W];
      w_data[k] = wr_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Hits are decoded unconditionally; the FSM only acts on them while running.
  always_comb begin
    w_flag_hit = '0;
    w_res_hit  = '0;
    w_flag_nxt = r_flag;
    w_pass_nxt = 1'b1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (wr_valid_i[k] && !r_ch_done[k]) begin
        if (w_addr[k] == flag_addr(k) && w_data[k] != '0) begin
          w_flag_hit[k]                    = 1'b1;
          w_flag_nxt[k*DATA_W +: DATA_W]   = w_data[k];
        end
        if (w_addr[k] == result_addr(k)) begin
          w_res_hit[k] = 1'b1;
        end
      end
      if (w_flag_nxt[k*DATA_W +: DATA_W] != DATA_W'(1)) begin
        w_pass_nxt = 1'b0;
      end
    end
    w_all_done = &(r_ch_done | w_flag_hit);
    w_expire   = (r_cycles == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_fetch_en <= '0;
      r_ch_done  <= '0;
      r_result   <= '0;
      r_flag     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
    end else begin
      case (r_state)
        StIdle, StDone, StTimeout: begin
          if (start_i) begin
            r_state    <= StRun;
            r_fetch_en <= '1;
            r_ch_done  <= '0;
            r_result   <= '0;
            r_flag     <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
          end
        end
        StRun: begin
          r_cycles <= r_cycles + CNT_W'(1);
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (w_res_hit[k]) begin
              r_result[k*DATA_W +: DATA_W] <= w_data[k];
            end
            if (w_flag_hit[k]) begin
              r_flag[k*DATA_W +: DATA_W] <= w_data[k];
              r_ch_done[k]               <= 1'b1;
              r_fetch_en[k]              <= 1'b0;
            end
          end
          // Completion takes priority over expiry in the same cycle.
          if (w_all_done) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_pass_nxt;
          end else if (w_expire) begin
            r_state    <= StTimeout;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b1;
            r_fetch_en <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fetch_en_o = r_fetch_en;
  assign ch_done_o  = r_ch_done;
  assign result_o   = r_result;
  assign flag_o     = r_flag;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign timeout_o  = r_timeout;
  assign cycles_o   = r_cycles;

endmodule

// File: tb/tb_soc_run_monitor.sv
// Directed bench: a 1-channel monitor (timeout 100) and a 2-channel monitor (timeout 40).
module tb_soc_run_monitor;

  logic        clk;
  logic        rst;
  int          n_chk;
  int          n_fail;

  logic        s1_start;
  logic [0:0]  s1_valid;
  logic [31:0] s1_addr;
  logic [31:0] s1_data;
  logic [0:0]  o1_fetch;
  logic [0:0]  o1_chdone;
  logic [31:0] o1_result;
  logic [31:0] o1_flag;
  logic        o1_busy, o1_done, o1_pass, o1_timeout;
  logic [31:0] o1_cycles;

  logic        s2_start;
  logic [1:0]  s2_valid;
  logic [63:0] s2_addr;
  logic [63:0] s2_data;
  logic [1:0]  o2_fetch;
  logic [1:0]  o2_chdone;
  logic [63:0] o2_result;
  logic [63:0] o2_flag;
  logic        o2_busy, o2_done, o2_pass, o2_timeout;
  logic [31:0] o2_cycles;

  soc_run_monitor #(
    .NUM_CH      (1),
    .TIMEOUT_CYC (100)
  ) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (s1_start),
    .wr_valid_i (s1_valid),
    .wr_addr_i  (s1_addr),
    .wr_data_i  (s1_data),
    .fetch_en_o (o1_fetch),
    .ch_done_o  (o1_chdone),
    .result_o   (o1_result),
    .flag_o     (o1_flag),
    .busy_o     (o1_busy),
    .done_o     (o1_done),
    .pass_o     (o1_pass),
    .timeout_o  (o1_timeout),
    .cycles_o   (o1_cycles)
  );

  soc_run_monitor #(
    .NUM_CH      (2),
    .TIMEOUT_CYC (40)
  ) u_dut2 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (s2_start),
    .wr_valid_i (s2_valid),
    .wr_addr_i  (s2_addr),
    .wr_data_i  (s2_data),
    .fetch_en_o (o2_fetch),
    .ch_done_o  (o2_chdone),
    .result_o   (o2_result),
    .flag_o     (o2_flag),
    .busy_o     (o2_busy),
    .done_o     (o2_done),
    .pass_o     (o2_pass),
    .timeout_o  (o2_timeout),
    .cycles_o   (o2_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w1(input logic [31:0] addr, input logic [31:0] data);
    s1_valid = 1'b1;
    s1_addr  = addr;
    s1_data  = data;
    tick();
    s1_valid = 1'b0;
  endtask

  task automatic start1();
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
  endtask

  task automatic start2();
    s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({o1_fetch, o1_chdone, o1_busy, o1_done, o1_pass, o1_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_status1: got %b want 000000",
               {o1_fetch, o1_chdone, o1_busy, o1_done, o1_pass, o1_timeout});
    end
    n_chk++;
    if ({o1_result, o1_flag, o1_cycles} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data1: got %h want 0", {o1_result, o1_flag, o1_cycles});
    end
    n_chk++;
    if ({o2_fetch, o2_chdone, o2_result, o2_flag, o2_cycles, o2_busy, o2_done, o2_pass,
         o2_timeout} !== 168'b0) begin
      n_fail++;
      $display("FAIL reset_all2: got %h want 0",
               {o2_fetch, o2_chdone, o2_result, o2_flag, o2_cycles});
    end
  endtask

  task automatic test_single_pass();
    start1();
    n_chk++;
    if ({o1_busy, o1_fetch, o1_cycles} !== {1'b1, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL single_enter: got busy=%b fetch=%b cyc=%0d want 1 1 0",
               o1_busy, o1_fetch, o1_cycles);
    end
    w1(32'h4, 32'd55);
    n_chk++;
    if (o1_result !== 32'd55 || o1_chdone !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got %0d done=%b want 55 0", o1_result, o1_chdone);
    end
    w1(32'h0, 32'd1);
    n_chk++;
    if ({o1_done, o1_pass, o1_fetch, o1_busy, o1_timeout, o1_chdone} !== 6'b110001) begin
      n_fail++;
      $display("FAIL single_done: got %b want 110001",
               {o1_done, o1_pass, o1_fetch, o1_busy, o1_timeout, o1_chdone});
    end
    n_chk++;
    if (o1_flag !== 32'd1 || o1_cycles !== 32'd2) begin
      n_fail++;
      $display("FAIL single_flag_cyc: got flag=%0d cyc=%0d want 1 2", o1_flag, o1_cycles);
    end
    w1(32'h4, 32'd99);
    tick();
    n_chk++;
    if (o1_result !== 32'd55 || o1_cycles !== 32'd2) begin
      n_fail++;
      $display("FAIL single_frozen: got res=%0d cyc=%0d want 55 2", o1_result, o1_cycles);
    end
  endtask

  task automatic test_timeout();
    start1();
    n_chk++;
    if ({o1_result, o1_flag, o1_cycles} !== 96'b0 || o1_chdone !== 1'b0 || o1_done !== 1'b0)
    begin
      n_fail++;
      $display("FAIL restart_clear: got res=%0d flag=%0d cyc=%0d done=%b want 0",
               o1_result, o1_flag, o1_cycles, o1_done);
    end
    repeat (49) tick();
    start1();
    repeat (49) tick();
    n_chk++;
    if (o1_busy !== 1'b1 || o1_timeout !== 1'b0 || o1_cycles !== 32'd99) begin
      n_fail++;
      $display("FAIL timeout_pre: got busy=%b to=%b cyc=%0d want 1 0 99",
               o1_busy, o1_timeout, o1_cycles);
    end
    tick();
    n_chk++;
    if ({o1_timeout, o1_done, o1_busy, o1_fetch, o1_pass} !== 5'b10000) begin
      n_fail++;
      $display("FAIL timeout_status: got %b want 10000",
               {o1_timeout, o1_done, o1_busy, o1_fetch, o1_pass});
    end
    n_chk++;
    if (o1_cycles !== 32'd100) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d want 100", o1_cycles);
    end
  endtask

  task automatic test_ignored_writes();
    start1();
    w1(32'h4, 32'd77);
    w1(32'h0, 32'd0);
    n_chk++;
    if (o1_chdone !== 1'b0 || o1_busy !== 1'b1 || o1_flag !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_flag: got chd=%b busy=%b flag=%0d want 0 1 0",
               o1_chdone, o1_busy, o1_flag);
    end
    w1(32'h8, 32'd1);
    n_chk++;
    if (o1_chdone !== 1'b0 || o1_result !== 32'd77) begin
      n_fail++;
      $display("FAIL other_addr: got chd=%b res=%0d want 0 77", o1_chdone, o1_result);
    end
    w1(32'h0, 32'd1);
    w1(32'h4, 32'd88);
    n_chk++;
    if (o1_result !== 32'd77 || o1_done !== 1'b1 || o1_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL late_result: got res=%0d done=%b pass=%b want 77 1 1",
               o1_result, o1_done, o1_pass);
    end
  endtask

  task automatic test_two_ch();
    start2();
    repeat (10) tick();
    s2_valid = 2'b10;
    s2_addr  = {32'h8, 32'h0};
    s2_data  = {32'd1, 32'd0};
    tick();
    s2_valid = 2'b00;
    n_chk++;
    if (o2_chdone !== 2'b10 || o2_fetch !== 2'b01 || o2_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL two_first: got chd=%b fetch=%b busy=%b want 10 01 1",
               o2_chdone, o2_fetch, o2_busy);
    end
    s2_valid = 2'b10;
    s2_addr  = {32'hC, 32'h0};
    s2_data  = {32'd5, 32'd0};
    tick();
    s2_valid = 2'b00;
    n_chk++;
    if (o2_result !== 64'd0) begin
      n_fail++;
      $display("FAIL two_after_done: got %h want 0", o2_result);
    end
    repeat (8) tick();
    s2_valid = 2'b01;
    s2_addr  = {32'h0, 32'h0};
    s2_data  = {32'd0, 32'd3};
    tick();
    s2_valid = 2'b00;
    n_chk++;
    if ({o2_done, o2_pass, o2_timeout, o2_chdone, o2_fetch} !== 7'b1001100) begin
      n_fail++;
      $display("FAIL two_done: got %b want 1001100",
               {o2_done, o2_pass, o2_timeout, o2_chdone, o2_fetch});
    end
    n_chk++;
    if (o2_flag !== {32'd1, 32'd3} || o2_cycles !== 32'd21) begin
      n_fail++;
      $display("FAIL two_flags: got flag=%h cyc=%0d want 0000000100000003 21",
               o2_flag, o2_cycles);
    end
  endtask

  task automatic test_edge_done();
    start2();
    repeat (5) tick();
    s2_valid = 2'b10;
    s2_addr  = {32'h8, 32'h0};
    s2_data  = {32'd1, 32'd0};
    tick();
    s2_valid = 2'b00;
    repeat (33) tick();
    n_chk++;
    if (o2_busy !== 1'b1 || o2_cycles !== 32'd39) begin
      n_fail++;
      $display("FAIL edge_pre: got busy=%b cyc=%0d want 1 39", o2_busy, o2_cycles);
    end
    s2_valid = 2'b01;
    s2_addr  = {32'h0, 32'h0};
    s2_data  = {32'd0, 32'd1};
    tick();
    s2_valid = 2'b00;
    n_chk++;
    if ({o2_done, o2_timeout, o2_pass, o2_busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL edge_done: got done/to/pass/busy=%b want 1010",
               {o2_done, o2_timeout, o2_pass, o2_busy});
    end
    n_chk++;
    if (o2_cycles !== 32'd40) begin
      n_fail++;
      $display("FAIL edge_cycles: got %0d want 40", o2_cycles);
    end
  endtask

  task automatic test_reset_mid_run();
    start1();
    start2();
    w1(32'h4, 32'd44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({o1_fetch, o1_chdone, o1_busy, o1_done, o1_pass, o1_timeout, o1_result, o1_cycles}
        !== 70'b0) begin
      n_fail++;
      $display("FAIL midrst1: got busy=%b fetch=%b res=%0d cyc=%0d want 0",
               o1_busy, o1_fetch, o1_result, o1_cycles);
    end
    n_chk++;
    if ({o2_busy, o2_fetch, o2_cycles} !== 35'b0) begin
      n_fail++;
      $display("FAIL midrst2: got busy=%b fetch=%b cyc=%0d want 0",
               o2_busy, o2_fetch, o2_cycles);
    end
    start1();
    w1(32'h4, 32'd66);
    w1(32'h0, 32'd1);
    n_chk++;
    if (o1_done !== 1'b1 || o1_result !== 32'd66) begin
      n_fail++;
      $display("FAIL rerun_done: got done=%b res=%0d want 1 66", o1_done, o1_result);
    end
    start1();
    n_chk++;
    if ({o1_result, o1_flag, o1_cycles} !== 96'b0 || {o1_chdone, o1_fetch} !== 2'b01 ||
        {o1_done, o1_pass, o1_busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL restart_from_done: got res=%0d flag=%0d cyc=%0d chd=%b fetch=%b",
               o1_result, o1_flag, o1_cycles, o1_chdone, o1_fetch);
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s1_start = 1'b0;
    s1_valid = 1'b0;
    s1_addr  = '0;
    s1_data  = '0;
    s2_start = 1'b0;
    s2_valid = '0;
    s2_addr  = '0;
    s2_data  = '0;
    test_reset();
    test_single_pass();
    test_timeout();
    test_ignored_writes();
    test_two_ch();
    test_edge_done();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
